// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the ALU issue scheduler.
// Data/command/flag widths, ALU control field position, flag bit indices.
package alu_sched_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 64;
    localparam int FLAG_W = 4;

    // ALU control lives in commands[4:2]
    localparam int CTRL_LSB = 2;
    localparam int CTRL_W   = 3;

    // Flag vector layout {carry, overflow, zero, negative}
    localparam int FLAG_NEG   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_CARRY = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CMD_W-1:0]  cmd_t;
    typedef logic [FLAG_W-1:0] flags_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t ALU_ADD = 3'd0;
    localparam ctrl_t ALU_SUB = 3'd1;
    localparam ctrl_t ALU_AND = 3'd2;
    localparam ctrl_t ALU_OR  = 3'd3;
    localparam ctrl_t ALU_XOR = 3'd4;

    function automatic ctrl_t cmd_ctrl(input cmd_t c);
        return c[CTRL_LSB +: CTRL_W];
    endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
// Ports: clk_i, reset_i, req_i, enable_i -> grant_o (one-hot), grant_idx_o.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [N-1:0]  req_i,
    input  logic          enable_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand [N];
    logic          found;

    // grant_idx_o falls back to the pointer when nothing wins, so the
    // downstream operand mux always has a defined, stable select.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = ptr_q;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand[k] = IW'((int'(ptr_q) + k) % N);
        end
        for (int k = 0; k < N; k++) begin
            if (!found && enable_i && req_i[cand[k]]) begin
                found          = 1'b1;
                grant_o        = '0;
                grant_o[cand[k]] = 1'b1;
                grant_idx_o    = cand[k];
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = IW'((int'(grant_idx_o) + 1) % N);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one ALU issue stage between NUM_RS reservation stations and
// holds the result in a single-entry slot until the CDB accepts it.
// In: rsReady/rsVal1/rsVal2/rsCommands/rsTag (packed per RS), aluResult,
//     aluFlags, cdbAck, flush. Out: grant, stallRS, aluA/B/Cntrl,
//     execute{Val,Flags,Commands,Tag}, valid, stallCycles.
module alu_issue_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_RS     = 4,
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_RS-1:0]            rsReady_i,
    input  logic [NUM_RS*64-1:0]         rsVal1_i,
    input  logic [NUM_RS*64-1:0]         rsVal2_i,
    input  logic [NUM_RS*10-1:0]         rsCommands_i,
    input  logic [NUM_RS*ROBsizeLog-1:0] rsTag_i,
    output logic [NUM_RS-1:0]            grant_o,
    output logic [NUM_RS-1:0]            stallRS_o,
    output logic [63:0]                  aluA_o,
    output logic [63:0]                  aluB_o,
    output logic [2:0]                   aluCntrl_o,
    input  logic [63:0]                  aluResult_i,
    input  logic [3:0]                   aluFlags_i,
    input  logic                         cdbAck_i,
    input  logic                         flush_i,
    output logic [63:0]                  executeVal_o,
    output logic [3:0]                   executeFlags_o,
    output logic [9:0]                   executeCommands_o,
    output logic [ROBsizeLog-1:0]        executeTag_o,
    output logic                         valid_o,
    output logic [15:0]                  stallCycles_o
);

    localparam int IW = $clog2(NUM_RS);

    data_t                 val1 [NUM_RS];
    data_t                 val2 [NUM_RS];
    cmd_t                  cmd  [NUM_RS];
    logic [ROBsizeLog-1:0] tag  [NUM_RS];

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            val1[i] = rsVal1_i[i*DATA_W +: DATA_W];
            val2[i] = rsVal2_i[i*DATA_W +: DATA_W];
            cmd[i]  = rsCommands_i[i*CMD_W +: CMD_W];
            tag[i]  = rsTag_i[i*ROBsizeLog +: ROBsizeLog];
        end
    end

    logic                  valid_q, valid_d;
    data_t                 val_q, val_d;
    flags_t                flags_q, flags_d;
    cmd_t                  cmd_q, cmd_d;
    logic [ROBsizeLog-1:0] tag_q, tag_d;
    logic [15:0]           stall_q, stall_d;

    logic          slot_free;
    logic          issue_en;
    logic          granted;
    logic [IW-1:0] sel;

    assign slot_free = ~valid_q | cdbAck_i;
    assign issue_en  = slot_free & ~flush_i & ~reset_i;
    assign granted   = |grant_o;

    rr_arbiter #(
        .N (NUM_RS)
    ) u_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (rsReady_i),
        .enable_i    (issue_en),
        .grant_o     (grant_o),
        .grant_idx_o (sel)
    );

    assign stallRS_o  = rsReady_i & ~grant_o;
    assign aluA_o     = val1[sel];
    assign aluB_o     = val2[sel];
    assign aluCntrl_o = cmd_ctrl(cmd[sel]);

    // Flush wins over both a new issue and an ack; a new issue refills
    // the slot even when the old entry is being acked the same cycle.
    always_comb begin
        valid_d = valid_q;
        val_d   = val_q;
        flags_d = flags_q;
        cmd_d   = cmd_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (granted) begin
            valid_d = 1'b1;
            val_d   = aluResult_i;
            flags_d = aluFlags_i;
            cmd_d   = cmd[sel];
            tag_d   = tag[sel];
        end else if (cdbAck_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (|rsReady_i && !granted && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            val_q   <= '0;
            flags_q <= '0;
            cmd_q   <= '0;
            tag_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            val_q   <= val_d;
            flags_q <= flags_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            stall_q <= stall_d;
        end
    end

    assign valid_o           = valid_q;
    assign executeVal_o      = val_q;
    assign executeFlags_o    = flags_q;
    assign executeCommands_o = cmd_q;
    assign executeTag_o      = tag_q;
    assign stallCycles_o     = stall_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: table vectors, hand
// sequences for multi-cycle corners, and a randomized reference model.
module tb_alu_issue_scheduler;

    localparam int N  = 4;
    localparam int TW = 4;

    localparam logic [9:0] CMD_ADD = 10'h000;
    localparam logic [9:0] CMD_SUB = 10'h004;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    rsReady_i;
    logic [N*64-1:0] rsVal1_i;
    logic [N*64-1:0] rsVal2_i;
    logic [N*10-1:0] rsCommands_i;
    logic [N*TW-1:0] rsTag_i;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    stallRS_o;
    logic [63:0]     aluA_o;
    logic [63:0]     aluB_o;
    logic [2:0]      aluCntrl_o;
    logic [63:0]     aluResult_i;
    logic [3:0]      aluFlags_i;
    logic            cdbAck_i;
    logic            flush_i;
    logic [63:0]     executeVal_o;
    logic [3:0]      executeFlags_o;
    logic [9:0]      executeCommands_o;
    logic [TW-1:0]   executeTag_o;
    logic            valid_o;
    logic [15:0]     stallCycles_o;

    logic [63:0]   va [N];
    logic [63:0]   vb [N];
    logic [9:0]    cm [N];
    logic [TW-1:0] tg [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_scheduler #(.NUM_RS(N), .ROBsize(8)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .rsReady_i         (rsReady_i),
        .rsVal1_i          (rsVal1_i),
        .rsVal2_i          (rsVal2_i),
        .rsCommands_i      (rsCommands_i),
        .rsTag_i           (rsTag_i),
        .grant_o           (grant_o),
        .stallRS_o         (stallRS_o),
        .aluA_o            (aluA_o),
        .aluB_o            (aluB_o),
        .aluCntrl_o        (aluCntrl_o),
        .aluResult_i       (aluResult_i),
        .aluFlags_i        (aluFlags_i),
        .cdbAck_i          (cdbAck_i),
        .flush_i           (flush_i),
        .executeVal_o      (executeVal_o),
        .executeFlags_o    (executeFlags_o),
        .executeCommands_o (executeCommands_o),
        .executeTag_o      (executeTag_o),
        .valid_o           (valid_o),
        .stallCycles_o     (stallCycles_o)
    );

    // External ALU stand-in: {flags, result}
    function automatic logic [67:0] alu_f(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [2:0] op);
        logic [64:0] w;
        logic [63:0] r;
        logic        c, v;
        w = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                v = (a[63] == b[63]) && (w[63] != a[63]);
                c = w[64];
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                v = (a[63] != b[63]) && (w[63] != a[63]);
                c = w[64];
            end
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        r = w[63:0];
        return {c, v, (r == 64'd0), r[63], r};
    endfunction

    assign {aluFlags_i, aluResult_i} = alu_f(aluA_o, aluB_o, aluCntrl_o);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rsVal1_i[i*64 +: 64]     = va[i];
            rsVal2_i[i*64 +: 64]     = vb[i];
            rsCommands_i[i*10 +: 10] = cm[i];
            rsTag_i[i*TW +: TW]      = tg[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    logic [63:0] m_val;
    logic [3:0]  m_flags;
    logic [9:0]  m_cmd;
    logic [TW-1:0] m_tag;
    int          m_stall;
    logic [N-1:0] last_grant;

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_val   = '0;
        m_flags = '0;
        m_cmd   = '0;
        m_tag   = '0;
        m_stall = 0;
    endtask

    // One clock: drive, check combinational outputs against the model,
    // advance the model, clock, then check the registered outputs.
    task automatic cycle(input logic [N-1:0] rdy, input bit ack,
                         input bit fl, input bit rst);
        bit          en;
        int          gi;
        int          s;
        logic [N-1:0] eg;
        logic [67:0] ar;
        rsReady_i = rdy;
        cdbAck_i  = ack;
        flush_i   = fl;
        reset_i   = rst;
        #1;
        en = (!m_valid || ack) && !fl && !rst;
        gi = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && rdy[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        s = (gi >= 0) ? gi : m_ptr;
        last_grant = grant_o;
        chk("grant", 64'(grant_o), 64'(eg));
        chk("stallRS", 64'(stallRS_o), 64'(rdy & ~eg));
        chk("aluA", aluA_o, va[s]);
        chk("aluB", aluB_o, vb[s]);
        chk("aluCntrl", 64'(aluCntrl_o), 64'(cm[s][4:2]));
        ar = alu_f(va[s], vb[s], cm[s][4:2]);
        if (rst) begin
            model_reset();
        end else begin
            if (rdy != 0 && gi < 0 && m_stall < 65535) m_stall++;
            if (fl) begin
                m_valid = 0;
            end else if (gi >= 0) begin
                m_valid = 1;
                m_val   = ar[63:0];
                m_flags = ar[67:64];
                m_cmd   = cm[gi];
                m_tag   = tg[gi];
                m_ptr   = (gi + 1) % N;
            end else if (ack) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(valid_o), 64'(m_valid));
        chk("execVal", executeVal_o, m_val);
        chk("execFlags", 64'(executeFlags_o), 64'(m_flags));
        chk("execCmd", 64'(executeCommands_o), 64'(m_cmd));
        chk("execTag", 64'(executeTag_o), 64'(m_tag));
        chk("stallCycles", 64'(stallCycles_o), 64'(m_stall));
    endtask

    typedef struct {
        logic [N-1:0] ready;
        logic [N-1:0] grant;
    } arb_vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [9:0]  cmd;
        logic [63:0] val;
        logic [3:0]  flags;
    } alu_vec_t;

    arb_vec_t arb_tab [10];
    alu_vec_t alu_tab [6];

    initial begin
        arb_tab[0] = '{4'b1111, 4'b0001};
        arb_tab[1] = '{4'b1111, 4'b0010};
        arb_tab[2] = '{4'b1111, 4'b0100};
        arb_tab[3] = '{4'b1111, 4'b1000};
        arb_tab[4] = '{4'b1111, 4'b0001};
        arb_tab[5] = '{4'b1010, 4'b0010};
        arb_tab[6] = '{4'b1001, 4'b1000};
        arb_tab[7] = '{4'b0000, 4'b0000};
        arb_tab[8] = '{4'b0100, 4'b0100};
        arb_tab[9] = '{4'b0111, 4'b0001};

        alu_tab[0] = '{64'd15, 64'd3, CMD_ADD, 64'd18, 4'b0000};
        alu_tab[1] = '{64'd5, 64'd5, CMD_SUB, 64'd0, 4'b0010};
        alu_tab[2] = '{64'd0, 64'd1, CMD_SUB, 64'hFFFF_FFFF_FFFF_FFFF,
                       4'b1001};
        alu_tab[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, CMD_ADD, 64'd0,
                       4'b1010};
        alu_tab[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, CMD_ADD,
                       64'h8000_0000_0000_0000, 4'b0101};
        alu_tab[5] = '{64'd100, 64'd58, CMD_SUB, 64'd42, 4'b0000};

        for (int i = 0; i < N; i++) begin
            va[i] = 64'(100 + i);
            vb[i] = 64'(i);
            cm[i] = CMD_ADD;
            tg[i] = TW'(i + 4);
        end
        rsReady_i = '0;
        cdbAck_i  = 1'b0;
        flush_i   = 1'b0;
        reset_i   = 1'b1;
        last_grant = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_val", executeVal_o, 64'd0);
        chk("rst_flags", 64'(executeFlags_o), 64'd0);
        chk("rst_cmd", 64'(executeCommands_o), 64'd0);
        chk("rst_tag", 64'(executeTag_o), 64'd0);
        chk("rst_stall", 64'(stallCycles_o), 64'd0);

        // First issue: 15 + 3 on RS0, tag 3
        va[0] = 64'd15; vb[0] = 64'd3; cm[0] = CMD_ADD; tg[0] = 4'd3;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        chk("t1_grant", 64'(last_grant), 64'h1);
        chk("t1_valid", 64'(valid_o), 64'd1);
        chk("t1_val", executeVal_o, 64'd18);
        chk("t1_tag", 64'(executeTag_o), 64'd3);
        chk("t1_zero", 64'(executeFlags_o[1]), 64'd0);

        // Round-robin order with the slot drained every cycle
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(arb_tab[i].ready, 1'b1, 1'b0, 1'b0);
            chk("rr_grant", 64'(last_grant), 64'(arb_tab[i].grant));
            chk("rr_stall", 64'(stallCycles_o), 64'd0);
        end

        // Slot full, no ack: requesters stall, then ack releases RS1
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0110, 1'b0, 1'b0, 1'b0);
            chk("full_grant", 64'(last_grant), 64'd0);
            chk("full_stallRS", 64'(stallRS_o), 64'(4'b0110));
            chk("full_val", executeVal_o, 64'd18);
        end
        chk("full_stallcnt", 64'(stallCycles_o), 64'd3);
        cycle(4'b0110, 1'b1, 1'b0, 1'b0);
        chk("ack_grant", 64'(last_grant), 64'(4'b0010));

        // ALU results and flags through RS0
        for (int i = 0; i < 6; i++) begin
            va[0] = alu_tab[i].a;
            vb[0] = alu_tab[i].b;
            cm[0] = alu_tab[i].cmd;
            cycle(4'b0001, 1'b1, 1'b0, 1'b0);
            chk("alu_val", executeVal_o, alu_tab[i].val);
            chk("alu_flags", 64'(executeFlags_o), 64'(alu_tab[i].flags));
        end

        // Flush beats ack and issue; pointer holds across it
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(4'b0001, 1'b1, 1'b1, 1'b0);
        chk("flush_grant", 64'(last_grant), 64'd0);
        chk("flush_valid", 64'(valid_o), 64'd0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("flush_ptr", 64'(last_grant), 64'(4'b0010));

        // Reset mid-stream with the slot occupied
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        chk("mrst_grant", 64'(last_grant), 64'd0);
        chk("mrst_valid", 64'(valid_o), 64'd0);
        chk("mrst_val", executeVal_o, 64'd0);
        chk("mrst_stall", 64'(stallCycles_o), 64'd0);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("mrst_first", 64'(last_grant), 64'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                va[i] = {$urandom, $urandom};
                vb[i] = ($urandom % 4 == 0) ? va[i] : {$urandom, $urandom};
                cm[i] = 10'($urandom);
                tg[i] = TW'($urandom);
            end
            cycle(N'($urandom), ($urandom % 3) != 0,
                  ($urandom % 12) == 0, ($urandom % 80) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- Shares one ALU issue/execute stage between NUM_RS reservation stations.
- Grant policy is round-robin.
- Muxes the winner's operands, commands and tag onto the ALU inputs, then registers the ALU result plus its flags into a single-entry output slot.
- Holds that slot until the common data bus (CDB) arbiter accepts it.
- Sits between the ALU reservation stations and the CDB/ROB writeback.

Parameters:
- NUM_RS, 4, number of requesting reservation stations (2..8).
- ROBsize, 8, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- rsReady_i  in  NUM_RS  per-RS request: operands ready.
- rsVal1_i  in  NUM_RS*64  packed operand A; RS i occupies bits [64i+63:64i].
- rsVal2_i  in  NUM_RS*64  packed operand B, same packing.
- rsCommands_i  in  NUM_RS*10  packed command words.
- rsTag_i  in  NUM_RS*ROBsizeLog  packed ROB tags.
- grant_o  out  NUM_RS  one-hot grant, combinational.
- stallRS_o  out  NUM_RS  rsReady_i & ~grant_o.
- aluA_o  out  64  selected operand A, to ALU A.
- aluB_o  out  64  selected operand B, to ALU B.
- aluCntrl_o  out  3  selected commands[4:2], to ALU cntrl.
- aluResult_i  in  64  ALU result.
- aluFlags_i  in  4  ALU flags: {carry_out, overflow, zero, negative} = [3:0].
- cdbAck_i  in  1  CDB accepts the output slot this cycle.
- flush_i  in  1  discard the slot and suppress issue (mispredict).
- executeVal_o  out  64  registered result.
- executeFlags_o  out  4  registered flags.
- executeCommands_o  out  10  registered command word.
- executeTag_o  out  ROBsizeLog  registered tag.
- valid_o  out  1  output slot occupied.
- stallCycles_o  out  16  saturating count of cycles with ready requests but no grant.

Behaviour:
- Reset (reset_i=1 at a clock edge; this overrides everything):
  - valid_o=0; executeVal_o, executeFlags_o, executeCommands_o and executeTag_o = 0.
  - Round-robin pointer ptr=0; stallCycles_o=0.
  - grant_o=0 while reset_i is high.
- slotFree = ~valid_o | cdbAck_i.
- issueEn = slotFree & ~flush_i & ~reset_i.
- Grant selection:
  - If issueEn and |rsReady_i, grant the first ready index scanning ptr, ptr+1, ..., wrapping modulo NUM_RS.
  - Otherwise grant_o=0.
- ALU inputs:
  - aluA_o, aluB_o and aluCntrl_o are taken from the granted RS.
  - With no grant they are taken from RS index ptr. The value is don't-care but must be stable, with no X.
- Issue latency: the grant in cycle N is captured at edge N+1.
  - Captured: valid_o=1, aluResult_i, aluFlags_i, and the granted command word and tag.
  - Throughput is one issue per cycle while cdbAck_i is held high.
- ptr update: on a grant, ptr <= grantedIndex+1 mod NUM_RS. Otherwise ptr holds.
- Slot behaviour:
  - cdbAck_i with valid_o=1 and no new grant: valid_o <= 0; data registers hold.
  - cdbAck_i with valid_o=0: ignored.
  - Slot full and no ack: all outputs hold, grant_o=0, all ready requesters stall.
- flush_i (takes priority over cdbAck_i and over issue):
  - valid_o <= 0 at the next edge.
  - No grant in the flush cycle; ptr holds.
- stallCycles_o:
  - Increments when |rsReady_i & ~|grant_o & ~reset_i.
  - Saturates at 16'hFFFF.
- The stallRS_o/canGo relationship is preserved: a requester not granted must hold its entry.
- rsReady_i is never required to be one-hot.

Decomposition:
- Shared package alu_sched_pkg:
  - CMD_W=10, DATA_W=64, FLAG_W=4.
  - ALU control field position (commands[4:2]).
  - Flag bit index constants FLAG_NEG=0, FLAG_ZERO=1, FLAG_OVF=2, FLAG_CARRY=3.
- One sub-module, rr_arbiter:
  - Parameterized on N.
  - Ports: req, enable, one-hot grant, grant index.
  - Owns the pointer register, with clk_i/reset_i.
- The datapath mux and output slot stay in the top level.

Test Plan:
1. Reset, then rsReady_i=4'b0001 with RS0 A=15, B=3, add control, tag 3 -> grant_o=0001 same cycle; next cycle valid_o=1, executeVal_o=18, executeTag_o=3, executeFlags_o[1]=0.
2. rsReady_i=4'b1111 held, cdbAck_i=1 every cycle -> grants 0001, 0010, 0100, 1000, 0001 in consecutive cycles; valid_o stays 1; stallCycles_o stays 0.
3. Slot full with cdbAck_i=0 for 3 cycles and rsReady_i=0110 -> grant_o=0, stallRS_o=0110, outputs frozen, stallCycles_o=3; ack in cycle 4 -> RS1 granted the same cycle.
4. A=5, B=5, subtract -> executeVal_o=0, zero flag executeFlags_o[1]=1; A=0, B=1 subtract -> negative flag [0]=1.
5. valid_o=1 with flush_i=1 and cdbAck_i=1 and rsReady_i=0001 -> no grant; next cycle valid_o=0; ptr unchanged (next grant still follows the prior order).
6. reset_i asserted mid-stream with valid_o=1 -> next cycle valid_o=0, all data outputs 0, stallCycles_o=0, first post-reset grant starts from RS0.
